// File: rtl/dircc_types_pkg.sv
// Shared DiRCC packet types: address/packet layout and the beat ordering
// used by both the packet sender and the packet receiver.
package dircc_types_pkg;

  typedef struct packed {
    logic [31:0] hw_addr;
    logic [15:0] sw_addr;
    logic [6:0]  port;
    logic        flag;
  } address_t;

  typedef struct packed {
    address_t    dest;
    address_t    src;
    logic [31:0] lamport;
    logic [95:0] data;
  } packet_t;

  localparam int PACKET_BEATS = 8;

  typedef enum logic [2:0] {
    EXPECT_DEST0,
    DEST1,
    SRC0,
    SRC1,
    LAMPORT,
    DATA0,
    DATA1,
    DATA2
  } rx_state_t;

endpackage

// File: rtl/dircc_avalon_st_packet_receiver_if.sv
// Avalon-ST beat channel (readyLatency 0) carrying DiRCC packets.
interface dircc_avalon_st_packet_receiver_if #(
  parameter int DATA_WIDTH  = 32,
  parameter int EMPTY_WIDTH = 2
);
  logic [DATA_WIDTH-1:0]  data;
  logic [EMPTY_WIDTH-1:0] empty;
  logic                   startofpacket;
  logic                   endofpacket;
  logic                   valid;
  logic                   ready;

  modport master (
    output data, empty, startofpacket, endofpacket, valid,
    input  ready
  );

  modport slave (
    input  data, empty, startofpacket, endofpacket, valid,
    output ready
  );
endinterface

// File: rtl/dircc_avalon_st_packet_receiver.sv
// Avalon-ST sink that reassembles the fixed 8-beat DiRCC packet into one
// packet_t, holds one complete packet for the consumer and counts framing
// errors with a saturating counter.
module dircc_avalon_st_packet_receiver
  import dircc_types_pkg::*;
#(
  parameter int BITS_PER_SYMBOL  = 8,
  parameter int SYMBOLS_PER_BEAT = 4,
  parameter int ERR_COUNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  dircc_avalon_st_packet_receiver_if.slave st,
  output packet_t                    packet_data,
  output logic                       packet_valid,
  input  logic                       read_packet,
  output logic                       receiving,
  output logic                       protocol_error,
  output logic [ERR_COUNT_WIDTH-1:0] error_count
);

  localparam int DATA_WIDTH  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
  localparam int EMPTY_WIDTH = $clog2(SYMBOLS_PER_BEAT);

  if (DATA_WIDTH != 32) begin : g_bad_data_width
    $error("dircc_avalon_st_packet_receiver: DATA_WIDTH must be 32");
  end

  rx_state_t                  r_state;
  rx_state_t                  w_next_state;
  packet_t                    r_assembly;
  packet_t                    w_next_assembly;
  packet_t                    w_completed_packet;
  packet_t                    r_packet_data;
  logic                       r_packet_valid;
  logic                       r_protocol_error;
  logic [ERR_COUNT_WIDTH-1:0] r_error_count;
  logic                       w_ready;
  logic                       w_accept;
  logic                       w_error;
  logic                       w_complete;
  logic                       w_empty_bad;
  logic [31:0]                w_beat;

  // The last beat stalls only when the holding register is full and not being popped.
  assign w_ready     = !reset && !(r_state == DATA2 && r_packet_valid && !read_packet);
  assign w_accept    = st.valid && w_ready;
  assign w_empty_bad = (st.empty != EMPTY_WIDTH'(0));
  assign w_beat      = st.data;

  assign st.ready       = w_ready;
  assign packet_data    = r_packet_data;
  assign packet_valid   = r_packet_valid;
  assign receiving      = (r_state != EXPECT_DEST0);
  assign protocol_error = r_protocol_error;
  assign error_count    = r_error_count;

  // Next-state and assembly decode; one framing error at most per beat, restart wins.
  always_comb begin
    w_next_state       = r_state;
    w_next_assembly    = r_assembly;
    w_completed_packet = r_assembly;
    w_error            = 1'b0;
    w_complete         = 1'b0;
    if (w_accept) begin
      if (r_state == EXPECT_DEST0) begin
        if (!st.startofpacket || w_empty_bad || st.endofpacket) begin
          w_error = 1'b1;
        end else begin
          w_next_assembly.dest.hw_addr = w_beat;
          w_next_state                 = DEST1;
        end
      end else if (st.startofpacket) begin
        w_error                      = 1'b1;
        w_next_assembly              = '0;
        w_next_assembly.dest.hw_addr = w_beat;
        w_next_state                 = DEST1;
      end else if (w_empty_bad) begin
        w_error      = 1'b1;
        w_next_state = EXPECT_DEST0;
      end else if (st.endofpacket != (r_state == DATA2)) begin
        w_error      = 1'b1;
        w_next_state = EXPECT_DEST0;
      end else begin
        case (r_state)
          DEST1: begin
            {w_next_assembly.dest.sw_addr, w_next_assembly.dest.port,
             w_next_assembly.dest.flag} = w_beat[31:8];
            w_next_state = SRC0;
          end
          SRC0: begin
            w_next_assembly.src.hw_addr = w_beat;
            w_next_state                = SRC1;
          end
          SRC1: begin
            {w_next_assembly.src.sw_addr, w_next_assembly.src.port,
             w_next_assembly.src.flag} = w_beat[31:8];
            w_next_state = LAMPORT;
          end
          LAMPORT: begin
            w_next_assembly.lamport = w_beat;
            w_next_state            = DATA0;
          end
          DATA0: begin
            w_next_assembly.data[31:0] = w_beat;
            w_next_state               = DATA1;
          end
          DATA1: begin
            w_next_assembly.data[63:32] = w_beat;
            w_next_state                = DATA2;
          end
          DATA2: begin
            w_completed_packet.data[95:64] = w_beat;
            w_complete                     = 1'b1;
            w_next_state                   = EXPECT_DEST0;
          end
          default: begin
            w_next_state = EXPECT_DEST0;
          end
        endcase
      end
    end
  end

  // Beat-position state and the partially assembled packet.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= EXPECT_DEST0;
      r_assembly <= '0;
    end else begin
      r_state    <= w_next_state;
      r_assembly <= w_next_assembly;
    end
  end

  // One-entry holding register; a completion in the same cycle as a pop reloads it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_packet_data  <= '0;
      r_packet_valid <= 1'b0;
    end else if (w_complete) begin
      r_packet_data  <= w_completed_packet;
      r_packet_valid <= 1'b1;
    end else if (read_packet && r_packet_valid) begin
      r_packet_valid <= 1'b0;
    end
  end

  // Error pulse and saturating error counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_protocol_error <= 1'b0;
      r_error_count    <= '0;
    end else begin
      r_protocol_error <= w_error;
      if (w_error && (r_error_count != '1)) begin
        r_error_count <= r_error_count + ERR_COUNT_WIDTH'(1);
      end
    end
  end

endmodule
